// File: rtl/const_loader.sv
// Constant ROM requester: fetches masked ROM constants LSB first and
// writes each valid one into consecutive operand RAM words.
module const_loader #(
  parameter int WIDTH  = 198,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [5:0]        mask,
  input  logic [ADDR_W-1:0] base,
  output logic [5:0]        const_addr,
  input  logic [WIDTH-1:0]  const_out,
  input  logic              const_effective,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CAPT = 2'd2
  } state_t;

  state_t              state_q;
  logic [5:0]          pend_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [ADDR_W-1:0]   base_q;
  logic [5:0]          caddr_q;
  logic                we_q;
  logic [ADDR_W-1:0]   waddr_q;
  logic [WIDTH-1:0]    wdata_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;

  logic [5:0]          src_d;
  logic [5:0]          pick_d;
  logic [5:0]          pend_d;

  // Lowest set bit of the fresh mask (IDLE) or of the pending set.
  always_comb begin
    src_d  = (state_q == IDLE) ? mask : pend_q;
    pick_d = src_d & (~src_d + 6'd1);
    pend_d = src_d & ~pick_d;
  end

  // Load sequencer: one-hot ROM request, one wait cycle, then capture.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
      idx_q   <= '0;
      base_q  <= '0;
      caddr_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            err_q <= 1'b0;
            if (mask != 6'd0) begin
              pend_q  <= pend_d;
              caddr_q <= pick_d;
              idx_q   <= '0;
              base_q  <= base;
              busy_q  <= 1'b1;
              state_q <= WAIT;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        WAIT: begin
          state_q <= CAPT;
        end
        CAPT: begin
          if (const_effective) begin
            we_q    <= 1'b1;
            waddr_q <= base_q + idx_q;
            wdata_q <= const_out;
            idx_q   <= idx_q + 1'b1;
          end else begin
            err_q <= 1'b1;
          end
          if (pend_q != 6'd0) begin
            caddr_q <= pick_d;
            pend_q  <= pend_d;
            state_q <= WAIT;
          end else begin
            caddr_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign const_addr = caddr_q;
  assign ram_we     = we_q;
  assign ram_addr   = waddr_q;
  assign ram_data   = wdata_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_const_loader.sv
// Directed bench for const_loader with a registered constant ROM model.
// Table of loads plus hand sequences for mid-load start and reset.
module tb_const_loader;

  localparam int W  = 198;
  localparam int AW = 6;

  logic          clk;
  logic          reset;
  logic          start;
  logic [5:0]    mask;
  logic [AW-1:0] base;
  logic [5:0]    const_addr;
  logic [W-1:0]  const_out;
  logic          const_effective;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [W-1:0]  ram_data;
  logic          busy;
  logic          done;
  logic          err;

  int n_chk;
  int n_bad;

  const_loader #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .mask            (mask),
    .base            (base),
    .const_addr      (const_addr),
    .const_out       (const_out),
    .const_effective (const_effective),
    .ram_we          (ram_we),
    .ram_addr        (ram_addr),
    .ram_data        (ram_data),
    .busy            (busy),
    .done            (done),
    .err             (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] rom_val(input int i);
    logic [W-1:0] v;
    case (i)
      0:       v = '0;
      1:       v = 198'd1;
      2:       v = {6'b000101, 192'd0};
      3:       v = {6'b001001, 192'd0};
      4:       v = {6'b010101, 192'd0};
      default: v = '1;
    endcase
    return v;
  endfunction

  // ROM model: one registered cycle, only one-hot addrs 1..16 are valid.
  always_ff @(posedge clk) begin
    case (const_addr)
      6'd1:    begin const_effective <= 1'b1; const_out <= rom_val(0); end
      6'd2:    begin const_effective <= 1'b1; const_out <= rom_val(1); end
      6'd4:    begin const_effective <= 1'b1; const_out <= rom_val(2); end
      6'd8:    begin const_effective <= 1'b1; const_out <= rom_val(3); end
      6'd16:   begin const_effective <= 1'b1; const_out <= rom_val(4); end
      default: begin const_effective <= 1'b0; const_out <= '1; end
    endcase
  end

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [5:0] m;
    logic [5:0] b;
    int         nw;
    logic       e;
    int         lat;
    logic [5:0] first;
    logic [5:0] last;
    int         poke;
  } vec_t;

  vec_t tbl[7];

  task automatic run(input vec_t v);
    int           lat;
    int           bcnt;
    int           nw;
    int           nexp;
    int           j;
    int           k2;
    logic [5:0]   ea;
    logic [AW-1:0] wa[8];
    logic [W-1:0]  wd[8];
    logic [5:0]   bits[6];
    nexp = 0;
    for (int i = 0; i < 6; i++)
      if (v.m[i]) begin
        bits[nexp] = 6'(1 << i);
        nexp++;
      end
    lat = -1;
    bcnt = 0;
    nw = 0;
    @(negedge clk);
    start = 1'b1;
    mask  = v.m;
    base  = v.b;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) start = 1'b0;
      if (k == v.poke) begin
        start = 1'b1;
        mask  = 6'b000001;
        base  = 6'd40;
      end
      if (v.poke >= 0 && k == v.poke + 1) start = 1'b0;
      if (k == 0) chk("err_clr_at_start", W'(err), W'(1'b0));
      if (busy) bcnt++;
      if (ram_we) begin
        if (nw < 8) begin
          wa[nw] = ram_addr;
          wd[nw] = ram_data;
        end
        nw++;
      end
      if (k < 2 * nexp) begin
        j = k / 2;
        chk("const_addr_seq", W'(const_addr), W'(bits[j]));
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("done_latency", W'(lat), W'(v.lat));
    chk("busy_cycles", W'(bcnt), W'(v.lat));
    chk("busy_low_at_done", W'(busy), W'(1'b0));
    chk("err_at_done", W'(err), W'(v.e));
    chk("const_addr_idle", W'(const_addr), W'(6'd0));
    chk("write_count", W'(nw), W'(v.nw));
    if (nw > 0 && nw <= 8) begin
      chk("first_addr", W'(wa[0]), W'(v.first));
      chk("last_addr", W'(wa[nw-1]), W'(v.last));
    end
    k2 = 0;
    for (int i = 0; i < 5; i++)
      if (v.m[i] && k2 < nw && k2 < 8) begin
        ea = v.b + 6'(k2);
        chk("word_addr", W'(wa[k2]), W'(ea));
        chk("word_data", wd[k2], rom_val(i));
        k2++;
      end
    @(posedge clk);
    #1;
    chk("done_pulse_end", W'(done), W'(1'b0));
    chk("we_pulse_end", W'(ram_we), W'(1'b0));
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    //        mask        base  nw err lat first last poke
    tbl[0] = '{6'b000010, 6'd5,  1, 0, 2,  6'd5,  6'd5,  -1};
    tbl[1] = '{6'b011111, 6'd0,  5, 0, 10, 6'd0,  6'd4,  -1};
    tbl[2] = '{6'b100001, 6'd3,  1, 1, 4,  6'd3,  6'd3,  -1};
    tbl[3] = '{6'b000010, 6'd0,  1, 0, 2,  6'd0,  6'd0,  -1};
    tbl[4] = '{6'b000110, 6'd63, 2, 0, 4,  6'd63, 6'd0,  -1};
    tbl[5] = '{6'b110000, 6'd10, 1, 1, 4,  6'd10, 6'd10, -1};
    tbl[6] = '{6'b011111, 6'd0,  5, 0, 10, 6'd0,  6'd4,   3};

    reset = 1'b0;
    start = 1'b0;
    mask  = '0;
    base  = '0;
    #12;
    chk("rst_const_addr", W'(const_addr), W'(6'd0));
    chk("rst_ram_we", W'(ram_we), W'(1'b0));
    chk("rst_ram_data", ram_data, '0);
    chk("rst_busy", W'(busy), W'(1'b0));
    chk("rst_done", W'(done), W'(1'b0));
    chk("rst_err", W'(err), W'(1'b0));
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 7; i++) run(tbl[i]);

    // reset while the second constant is being captured
    @(negedge clk);
    start = 1'b1;
    mask  = 6'b011111;
    base  = 6'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    #1;
    chk("mid_rst_const_addr", W'(const_addr), W'(6'd0));
    chk("mid_rst_ram_we", W'(ram_we), W'(1'b0));
    chk("mid_rst_ram_addr", W'(ram_addr), W'(6'd0));
    chk("mid_rst_ram_data", ram_data, '0);
    chk("mid_rst_busy", W'(busy), W'(1'b0));
    chk("mid_rst_done", W'(done), W'(1'b0));
    chk("mid_rst_err", W'(err), W'(1'b0));
    @(negedge clk);
    reset = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_we", W'(ram_we), W'(1'b0));
      chk("post_rst_idle", W'(busy), W'(1'b0));
    end

    // empty mask: lone done pulse, busy never rises
    @(negedge clk);
    start = 1'b1;
    mask  = 6'd0;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("empty_done", W'(done), W'(1'b1));
    chk("empty_busy", W'(busy), W'(1'b0));
    chk("empty_err", W'(err), W'(1'b0));
    @(posedge clk);
    #1;
    chk("empty_done_end", W'(done), W'(1'b0));
    chk("empty_busy_end", W'(busy), W'(1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
